// File: rtl/rotate_func.sv
// Rho rotation stage: buffers a 1600-bit state as 64 x 25-bit slices, then emits rotated slices.
// Latency 129 cycles start-to-done; no backpressure, the consumer takes one slice per cycle.
module rotate_func (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] line_in,
  output logic [6:0]  cnt_value,
  output logic        write_enable,
  output logic [24:0] write_value,
  output logic        donee
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [6:0]  cnt_inc;
  logic        load_en;
  logic [24:0] rot_slice;

  // Rotation offset of lane i = x + 5*y.
  function automatic logic [5:0] rot_amt(input int idx);
    logic [5:0] r;
    case (idx)
      0:  r = 6'd0;   1:  r = 6'd1;   2:  r = 6'd62;  3:  r = 6'd28;  4:  r = 6'd27;
      5:  r = 6'd36;  6:  r = 6'd44;  7:  r = 6'd6;   8:  r = 6'd55;  9:  r = 6'd20;
      10: r = 6'd3;   11: r = 6'd10;  12: r = 6'd43;  13: r = 6'd25;  14: r = 6'd39;
      15: r = 6'd41;  16: r = 6'd45;  17: r = 6'd15;  18: r = 6'd21;  19: r = 6'd8;
      20: r = 6'd18;  21: r = 6'd2;   22: r = 6'd61;  23: r = 6'd56;  24: r = 6'd14;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  assign cnt_inc = cnt_q + 7'd1;
  assign load_en = (state_q == LOAD);

  // Each lane holds one bit position across all 64 slices; the read index wraps mod 64.
  for (genvar i = 0; i < 25; i++) begin : g_lane
    logic [63:0] lane_q;
    logic [5:0]  rd_idx;

    always_ff @(posedge clk) begin
      if (load_en) lane_q[cnt_q[5:0]] <= line_in[i];
    end

    assign rd_idx       = cnt_q[5:0] - rot_amt(i);
    assign rot_slice[i] = lane_q[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Carry into bit 6 marks slice 63, so the counter never shows 64.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (cnt_inc[6]) begin
          state_d = EMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      EMIT: begin
        if (cnt_inc[6]) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cnt_value    = cnt_q;
    write_enable = (state_q == EMIT);
    donee        = (state_q == DONE);
    write_value  = write_enable ? rot_slice : '0;
  end

endmodule

// File: doc/rotate_func.md
# rotate_func

Rotation (rho) stage directly upstream of the permutation stage in the matrix-encoder pipeline. It reads a 1600-bit state as 64 slices of 25 bits, one slice per cycle. It buffers the whole state, because rotation moves bits between slices. It then emits 64 rotated slices with a write strobe, in the same slice order and format the permutation stage consumes on its line input.

## Interface
- Parameters: none. Geometry is fixed at 25-bit slice × 64 slices (1600-bit state).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled request; accepted only in IDLE.
- `line_in`  in  25  slice addressed by `cnt_value` during LOAD; combinationally valid in the same cycle.
- `cnt_value`  out  7  slice index: read address in LOAD, write address in EMIT; range 0..63.
- `write_enable`  out  1  high for each valid `write_value` in EMIT.
- `write_value`  out  25  rotated slice `cnt_value`.
- `donee`  out  1  one-cycle pulse after the last write.

## Operation
- Bit map: slice bit i = x + 5*y, with x,y in 0..4; slice index z in 0..63.
- Storage: 25 lanes × 64 bits, with lane (x,y) bit z = slice z, bit x+5y.
- Rotation: out[x,y,z] = in[x,y,(z − r(x,y)) mod 64]. Indexing is mod-64 (6-bit wrap); there is no arithmetic overflow path.
- r(x,y) for y=0: 0, 1, 62, 28, 27 (x=0..4).
- r(x,y) for y=1: 36, 44, 6, 55, 20.
- r(x,y) for y=2: 3, 10, 43, 25, 39.
- r(x,y) for y=3: 41, 45, 15, 21, 8.
- r(x,y) for y=4: 18, 2, 61, 56, 14.
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE → LOAD when `start`=1 at a clock edge; counter cleared to 0.
- LOAD: each edge stores `line_in` as slice `cnt_value` and increments the counter. At count 63 (carry-out), go to EMIT and clear the counter.
- EMIT: `write_enable`=1 and `write_value` = rotated slice `cnt_value`, combinational from storage. Counter increments each edge. At count 63, go to DONE.
- DONE: `donee`=1 for one cycle, then IDLE. Storage is retained.
- `start` in LOAD/EMIT/DONE is ignored; no queuing. `start` held high in DONE's following IDLE cycle begins a new run.
- `cnt_value` is 0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, `cnt_value`=0, `write_enable`=0, `write_value`=0, `donee`=0. Storage contents are don't-care after reset.
- `write_value` is forced to 0 whenever `write_enable`=0.
- Cycle count from the edge sampling `start` (edge 0):
  - LOAD occupies cycles 1..64, reading slices 0..63.
  - EMIT occupies cycles 65..128, writing slices 0..63.
  - DONE is cycle 129, with `donee` high.
  - Total 129 cycles start-to-done; next accept possible at the edge ending cycle 130.
- `write_enable` is high for exactly 64 consecutive cycles per run, with no gaps.
- Reset asserted mid-LOAD or mid-EMIT: outputs return to reset values immediately (asynchronously). No further writes occur; `donee` is not pulsed.
- Counter is 7 bits. Carry-out at 63 ends the phase, and the counter never exposes 64.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 immediately; FSM idle; `start` accepted after deassert.
- Latency/strobe: `start` pulse at edge 0 → `cnt_value` counts 0..63 in cycles 1..64; `write_enable` high in cycles 65..128 only; `donee` high in cycle 129 only.
- Single bit, no wrap: only slice 5 bit 6 set (x=1,y=1,z=5; r=44) → only output slice 49 bit 6 set; all other outputs zero.
- Wrap-around: only slice 10 bit 2 set (x=2,y=0; r=62) → output slice 8 bit 2 set. Only slice 63 bit 1 set (r=1) → output slice 0 bit 1 set.
- Identity lane and all-ones: slice 7 = 25'h0000001 (x=y=0, r=0) → output slice 7 = 25'h0000001. All slices 25'h1FFFFFF → all 64 outputs 25'h1FFFFFF.
- Busy/abort:
  - `start` held high through LOAD/EMIT → single run, then a second run begins immediately after DONE.
  - `rst` at cycle 90 (during EMIT) → `write_enable` drops at once; no `donee`; a fresh run produces correct output.
